// File: rtl/rc_pkg.sv
// Shared definitions for the result collector: default word width,
// frame length width and the frame-tracking FSM states.
package rc_pkg;

    localparam int DATA_W_DEFAULT = 21;
    localparam int FRAME_LEN_W    = 8;

    localparam logic [FRAME_LEN_W-1:0] FRAME_LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FRAME   = 2'd2
    } state_e;

endpackage

// File: rtl/rc_fifo.sv
// Synchronous FIFO for the result collector: storage, wrapping pointers,
// occupancy count, status flags and a registered read port.
// Optional feature macro: RESULT_COLLECTOR_PARITY_EN adds an even-parity
// bit per stored word and a parity-error pulse on the read port.
module rc_fifo
    import rc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
`ifdef RESULT_COLLECTOR_PARITY_EN
    output logic                      rd_parity_err,
`endif
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef RESULT_COLLECTOR_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    logic [MW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [MW-1:0]     wr_word;
    logic [MW-1:0]     rd_word;
`ifdef RESULT_COLLECTOR_PARITY_EN
    logic              parity_err_q, parity_err_d;
`endif

    // Build the stored word (data plus optional even-parity bit) and fetch the head word.
    always_comb begin
`ifdef RESULT_COLLECTOR_PARITY_EN
        wr_word = {^push_data, push_data};
`else
        wr_word = push_data;
`endif
        rd_word = mem_q[rd_ptr_q];
    end

    // Next-state for pointers, occupancy and the registered read port.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef RESULT_COLLECTOR_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = rd_word[DATA_W-1:0];
            rd_valid_d = 1'b1;
`ifdef RESULT_COLLECTOR_PARITY_EN
            parity_err_d = ^rd_word;
`endif
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and read-port registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef RESULT_COLLECTOR_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef RESULT_COLLECTOR_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Word storage written at the tail pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; a cleared count/pointer pair already makes old words unreachable.
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
`ifdef RESULT_COLLECTOR_PARITY_EN
    assign rd_parity_err = parity_err_q;
`endif

endmodule

// File: rtl/result_collector.sv
// Result collector: buffers producer words in a FIFO, tracks frames with
// an IDLE/COLLECT/FRAME state machine and reports length and overflow.
// Optional feature macro: RESULT_COLLECTOR_PARITY_EN (parity per stored word).
module result_collector
    import rc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_req,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      done,
    input  logic                      rd_en,
    input  logic                      clr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
`ifdef RESULT_COLLECTOR_PARITY_EN
    output logic                      rd_parity_err,
`endif
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      frame_done,
    output logic [FRAME_LEN_W-1:0]    frame_len,
    output logic                      overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e                 state_q, state_d;
    logic [FRAME_LEN_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
    logic                   overflow_q, overflow_d;
    logic                   push, pop, drop;
    logic [FRAME_LEN_W-1:0] cnt_inc;

    // Writes are refused when the buffer is full, or while a finished frame
    // is pending unless clr starts a new one in the same cycle.
    assign push    = wr_req && !full && ((state_q != FRAME) || clr);
    assign drop    = wr_req && !push;
    assign pop     = rd_en && !empty;
    assign cnt_inc = (frame_cnt_q == FRAME_LEN_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;

    rc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_data     (wr_data),
        .pop           (pop),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
`ifdef RESULT_COLLECTOR_PARITY_EN
        .rd_parity_err (rd_parity_err),
`endif
        .empty         (empty),
        .full          (full),
        .count         (count)
    );

    // Frame FSM next-state, frame word counter, latched length and sticky overflow.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        frame_len_d = frame_len_q;
        overflow_d  = clr ? 1'b0 : (overflow_q | drop);
        if (clr) begin
            state_d = push ? COLLECT : IDLE;
            if (push) frame_cnt_d = FRAME_LEN_W'(1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (done) begin
                        state_d     = FRAME;
                        frame_len_d = FRAME_LEN_W'(push);
                    end else if (push) begin
                        state_d     = COLLECT;
                        frame_cnt_d = FRAME_LEN_W'(1);
                    end
                end
                COLLECT: begin
                    if (push) frame_cnt_d = cnt_inc;
                    if (done) begin
                        state_d     = FRAME;
                        frame_len_d = push ? cnt_inc : frame_cnt_q;
                    end
                end
                FRAME: begin
                    // Leave as soon as the buffer is (or is about to be) drained.
                    if (!wr_req && (empty || (count == CW'(1) && pop))) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and frame bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            frame_len_q <= frame_len_d;
            overflow_q  <= overflow_d;
        end
    end

    assign frame_done = (state_q == FRAME);
    assign frame_len  = frame_len_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (DATA_W=21, DEPTH=8).
module tb_result_collector;

    localparam int DATA_W = 21;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic              rd_en;
    logic              clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
`ifdef RESULT_COLLECTOR_PARITY_EN
    logic              rd_parity_err;
`endif
    logic              empty;
    logic              full;
    logic [3:0]        count;
    logic              frame_done;
    logic [7:0]        frame_len;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;

    result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .done          (done),
        .rd_en         (rd_en),
        .clr           (clr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
`ifdef RESULT_COLLECTOR_PARITY_EN
        .rd_parity_err (rd_parity_err),
`endif
        .empty         (empty),
        .full          (full),
        .count         (count),
        .frame_done    (frame_done),
        .frame_len     (frame_len),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " empty"},      32'(empty),      32'd1);
        check({tag, " full"},       32'(full),       32'd0);
        check({tag, " count"},      32'(count),      32'd0);
        check({tag, " rd_valid"},   32'(rd_valid),   32'd0);
        check({tag, " rd_data"},    32'(rd_data),    32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " frame_len"},  32'(frame_len),  32'd0);
        check({tag, " overflow"},   32'(overflow),   32'd0);
    endtask

    initial begin
        rst = 1'b0; wr_req = 1'b0; wr_data = '0; done = 1'b0; rd_en = 1'b0; clr = 1'b0;
        #3;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Frame of three words, first accepted on the first edge after reset release.
        wr_req = 1'b1; wr_data = 21'h00001; step();
        check("first write count", 32'(count), 32'd1);
        wr_data = 21'h1FFFFF; step();
        wr_data = 21'h0AAAA;  step();
        wr_req = 1'b0; done = 1'b1; step();
        done = 1'b0;
        check("frame_done after done", 32'(frame_done), 32'd1);
        check("frame_len 3",           32'(frame_len),  32'd3);
        check("count 3",               32'(count),      32'd3);

        // Write while a frame is pending is dropped and flagged.
        wr_req = 1'b1; wr_data = 21'h00055; step();
        wr_req = 1'b0;
        check("frame drop count",    32'(count),      32'd3);
        check("frame drop overflow", 32'(overflow),   32'd1);
        check("frame drop frame_done", 32'(frame_done), 32'd1);

        // Drain the frame in order.
        rd_en = 1'b1; step();
        check("read0 valid", 32'(rd_valid), 32'd1);
        check("read0 data",  32'(rd_data),  32'h00001);
`ifdef RESULT_COLLECTOR_PARITY_EN
        check("read0 parity_err", 32'(rd_parity_err), 32'd0);
`endif
        step();
        check("read1 valid", 32'(rd_valid), 32'd1);
        check("read1 data",  32'(rd_data),  32'h1FFFFF);
        step();
        check("read2 valid",      32'(rd_valid),   32'd1);
        check("read2 data",       32'(rd_data),    32'h0AAAA);
        check("drained empty",    32'(empty),      32'd1);
        check("drained frame_done", 32'(frame_done), 32'd0);
        rd_en = 1'b0; step();
        check("idle rd_valid", 32'(rd_valid), 32'd0);
        rd_en = 1'b1; step();
        check("empty read valid", 32'(rd_valid), 32'd0);
        check("empty read data",  32'(rd_data),  32'h0AAAA);
        rd_en = 1'b0;
        clr = 1'b1; step();
        clr = 1'b0;
        check("clr overflow", 32'(overflow), 32'd0);

        // Fill past depth: eighth write fills, ninth is dropped.
        wr_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = DATA_W'(32'h100 + i);
            step();
            if (i == 7) begin
                check("fill8 full",     32'(full),     32'd1);
                check("fill8 count",    32'(count),    32'd8);
                check("fill8 overflow", 32'(overflow), 32'd0);
            end
        end
        wr_req = 1'b0;
        check("fill9 count",    32'(count),    32'd8);
        check("fill9 overflow", 32'(overflow), 32'd1);
        clr = 1'b1; step();
        clr = 1'b0;
        check("fill clr overflow", 32'(overflow), 32'd0);
        check("fill clr count",    32'(count),    32'd8);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fill drain data", 32'(rd_data), 32'h100 + i);
        end
        rd_en = 1'b0;
        check("fill drain empty", 32'(empty), 32'd1);

        // Simultaneous write and read at count 4 across the pointer wrap.
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = DATA_W'(32'h200 + i);
            step();
        end
        check("wrap count 4", 32'(count), 32'd4);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DATA_W'(32'h204 + i);
            step();
            check("wrap rw count", 32'(count),   32'd4);
            check("wrap rw data",  32'(rd_data), 32'h200 + i);
        end
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wrap drain data", 32'(rd_data), 32'h203 + i);
        end
        rd_en = 1'b0;
        check("wrap drain empty", 32'(empty), 32'd1);

        // clr with a write starts a fresh frame; done with a write counts it.
        clr = 1'b1; wr_req = 1'b1; wr_data = 21'h00301; step();
        clr = 1'b0;
        check("clr+write count", 32'(count), 32'd1);
        wr_data = 21'h00302; done = 1'b1; step();
        wr_req = 1'b0; done = 1'b0;
        check("done+write frame_done", 32'(frame_done), 32'd1);
        check("done+write frame_len",  32'(frame_len),  32'd2);

        // Asynchronous reset mid-frame, between edges.
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async reset");
        rst = 1'b1;

        // done in IDLE gives an empty frame that closes immediately.
        done = 1'b1; step();
        done = 1'b0;
        check("idle done frame_done", 32'(frame_done), 32'd1);
        check("idle done frame_len",  32'(frame_len),  32'd0);
        step();
        check("idle done exit", 32'(frame_done), 32'd0);

        // Word after reset lands at the head.
        wr_req = 1'b1; wr_data = 21'h00300; step();
        wr_req = 1'b0;
        check("post reset count", 32'(count), 32'd1);
`ifdef RESULT_COLLECTOR_PARITY_EN
        dut.u_fifo.mem_q[0] = dut.u_fifo.mem_q[0] ^ 22'h1;
`endif
        rd_en = 1'b1; step();
        rd_en = 1'b0;
        check("post reset valid", 32'(rd_valid), 32'd1);
`ifdef RESULT_COLLECTOR_PARITY_EN
        check("parity data",      32'(rd_data),       32'h00301);
        check("parity err pulse", 32'(rd_parity_err), 32'd1);
`else
        check("post reset data",  32'(rd_data),       32'h00300);
`endif
        step();
        check("final rd_valid low", 32'(rd_valid), 32'd0);
`ifdef RESULT_COLLECTOR_PARITY_EN
        check("parity err low", 32'(rd_parity_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
